// File: rtl/meas_scheduler_if.sv
// ---------------------------------------------------------------------------
// meas_scheduler_if
//   Bundles the control, configuration, engine-handshake and status signals
//   of the measurement scheduler.
//   master : the controlling side (drives start/abort/config and the engine
//            "done" levels, observes triggers and status)
//   slave  : the scheduler itself
//   Signals:
//     start, abort          one-cycle requests
//     cfg_en, cfg_each      config-phase selection
//     n_runs [RUN_W]        runs per sequence
//     t_gap, timeout [CNT_W] gap length and wait-state timeout (0 = none)
//     done_spi, done_task   level "done" indications from the engine
//     trigger_config/_task  one-cycle start pulses to the engine
//     busy, run_idx, seq_done, err_timeout, state   status
// ---------------------------------------------------------------------------
interface meas_scheduler_if #(
  parameter int RUN_W = 16,
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic             cfg_en;
  logic             cfg_each;
  logic [RUN_W-1:0] n_runs;
  logic [CNT_W-1:0] t_gap;
  logic [CNT_W-1:0] timeout;
  logic             done_spi;
  logic             done_task;

  logic             trigger_config;
  logic             trigger_task;
  logic             busy;
  logic [RUN_W-1:0] run_idx;
  logic             seq_done;
  logic             err_timeout;
  logic [2:0]       state;

  modport master (
    output start, abort, cfg_en, cfg_each, n_runs, t_gap, timeout,
           done_spi, done_task,
    input  trigger_config, trigger_task, busy, run_idx, seq_done,
           err_timeout, state
  );

  modport slave (
    input  start, abort, cfg_en, cfg_each, n_runs, t_gap, timeout,
           done_spi, done_task,
    output trigger_config, trigger_task, busy, run_idx, seq_done,
           err_timeout, state
  );
endinterface

// File: rtl/meas_scheduler.sv
// ---------------------------------------------------------------------------
// meas_scheduler
//   Sequences a measurement: an optional config transfer, then n_runs task
//   runs separated by t_gap idle cycles, with an optional config transfer
//   before every run. Wait states are guarded by an optional timeout.
//   Ports:
//     clk    system clock (rising edge)
//     rst_n  asynchronous active-low reset
//     bus    meas_scheduler_if.slave (see interface header for signals)
//   All outputs are registered. Trigger and seq_done pulses are produced on
//   the clock edge that leaves CFG / TASK / DONE, so an abort sampled in
//   those states suppresses the pulse.
// ---------------------------------------------------------------------------
module meas_scheduler #(
  parameter int RUN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  meas_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CFG       = 3'd1,
    S_WAIT_CFG  = 3'd2,
    S_TASK      = 3'd3,
    S_WAIT_TASK = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_idx_q, run_idx_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [RUN_W-1:0] n_runs_q, n_runs_d;
  logic [CNT_W-1:0] t_gap_q, t_gap_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_each_q, cfg_each_d;
  logic             err_q, err_d;
  logic             spi_prev_q, task_prev_q;
  logic             trig_cfg_q, trig_cfg_d;
  logic             trig_task_q, trig_task_d;
  logic             seq_done_q, seq_done_d;
  logic             busy_q;

  logic             spi_rise, task_rise;
  logic [CNT_W-1:0] timer_inc;
  logic [RUN_W-1:0] run_idx_inc;
  logic             timed_out;

  // Only a 0->1 transition counts as "done"; a level already high at
  // sequence start is ignored.
  assign spi_rise    = bus.done_spi  & ~spi_prev_q;
  assign task_rise   = bus.done_task & ~task_prev_q;
  assign timer_inc   = timer_q + CNT_W'(1);
  assign run_idx_inc = run_idx_q + RUN_W'(1);
  // timer_q counts completed wait cycles, so the comparison against
  // timer_inc fires on the timeout-th wait cycle.
  assign timed_out   = (timeout_q != '0) && (timer_inc == timeout_q);

  always_comb begin
    state_d     = state_q;
    run_idx_d   = run_idx_q;
    timer_d     = timer_q;
    n_runs_d    = n_runs_q;
    t_gap_d     = t_gap_q;
    timeout_d   = timeout_q;
    cfg_en_d    = cfg_en_q;
    cfg_each_d  = cfg_each_q;
    err_d       = err_q;
    trig_cfg_d  = 1'b0;
    trig_task_d = 1'b0;
    seq_done_d  = 1'b0;

    if (bus.abort) begin
      // Abort wins over everything, including a start in the same cycle.
      // run_idx and err_timeout are left as they are.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && (bus.n_runs != '0)) begin
            n_runs_d   = bus.n_runs;
            t_gap_d    = bus.t_gap;
            timeout_d  = bus.timeout;
            cfg_en_d   = bus.cfg_en;
            cfg_each_d = bus.cfg_each;
            run_idx_d  = '0;
            err_d      = 1'b0;
            state_d    = bus.cfg_en ? S_CFG : S_TASK;
          end
        end
        S_CFG: begin
          trig_cfg_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT_CFG;
        end
        S_WAIT_CFG: begin
          timer_d = timer_inc;
          if (spi_rise) begin
            state_d = S_TASK;
          end else if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_TASK: begin
          trig_task_d = 1'b1;
          timer_d     = '0;
          state_d     = S_WAIT_TASK;
        end
        S_WAIT_TASK: begin
          timer_d = timer_inc;
          if (task_rise) begin
            run_idx_d = run_idx_inc;
            if (run_idx_inc == n_runs_q) begin
              state_d = S_DONE;
            end else begin
              timer_d = '0;   // the timer doubles as the gap counter
              state_d = S_GAP;
            end
          end else if (timed_out) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_GAP: begin
          // t_gap = 0 still spends one cycle here.
          if ((t_gap_q == '0) || (timer_inc == t_gap_q)) begin
            state_d = (cfg_en_q && cfg_each_q) ? S_CFG : S_TASK;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_DONE: begin
          seq_done_d = 1'b1;
          state_d    = S_IDLE;
        end
        S_ERR: begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_idx_q   <= '0;
      timer_q     <= '0;
      n_runs_q    <= '0;
      t_gap_q     <= '0;
      timeout_q   <= '0;
      cfg_en_q    <= 1'b0;
      cfg_each_q  <= 1'b0;
      err_q       <= 1'b0;
      spi_prev_q  <= 1'b0;
      task_prev_q <= 1'b0;
      trig_cfg_q  <= 1'b0;
      trig_task_q <= 1'b0;
      seq_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_idx_q   <= run_idx_d;
      timer_q     <= timer_d;
      n_runs_q    <= n_runs_d;
      t_gap_q     <= t_gap_d;
      timeout_q   <= timeout_d;
      cfg_en_q    <= cfg_en_d;
      cfg_each_q  <= cfg_each_d;
      err_q       <= err_d;
      spi_prev_q  <= bus.done_spi;
      task_prev_q <= bus.done_task;
      trig_cfg_q  <= trig_cfg_d;
      trig_task_q <= trig_task_d;
      seq_done_q  <= seq_done_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.trigger_config = trig_cfg_q;
  assign bus.trigger_task   = trig_task_q;
  assign bus.seq_done       = seq_done_q;
  assign bus.busy           = busy_q;
  assign bus.run_idx        = run_idx_q;
  assign bus.err_timeout    = err_q;
  assign bus.state          = state_q;

endmodule

// File: doc/meas_scheduler.md
MEAS_SCHEDULER -- requirements
Module: meas_scheduler

Interface
REQ-001 Parameter RUN_W, default 16, SHALL set the width of the run counter and of n_runs.
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the gap and timeout counters.
REQ-003 clk  in  1  single system clock; every flop SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a measurement sequence.
REQ-006 abort  in  1  one-cycle request to cancel the sequence in progress.
REQ-007 cfg_en  in  1  issue a config phase before the first run.
REQ-008 cfg_each  in  1  issue a config phase before every run; takes effect only when cfg_en=1.
REQ-009 n_runs  in  RUN_W  number of task runs per sequence.
REQ-010 t_gap  in  CNT_W  idle clk cycles between consecutive runs.
REQ-011 timeout  in  CNT_W  maximum clk cycles spent in a wait state; 0 disables the timeout.
REQ-012 done_spi  in  1  level "config done" from the SPI/task engine.
REQ-013 done_task  in  1  level "task done" from the SPI/task engine.
REQ-014 trigger_config  out  1  one-cycle pulse that starts a config transfer.
REQ-015 trigger_task  out  1  one-cycle pulse that starts a task.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 run_idx  out  RUN_W  number of runs completed in the current sequence.
REQ-018 seq_done  out  1  one-cycle pulse on normal completion.
REQ-019 err_timeout  out  1  sticky flag, set when a wait state times out.
REQ-020 state  out  3  encoding: IDLE=0, CFG=1, WAIT_CFG=2, TASK=3, WAIT_TASK=4, GAP=5, DONE=6, ERR=7.

Function
REQ-021 All outputs SHALL be registered; start, abort and the done inputs act at the clk edge where they are sampled.
REQ-022 The block SHALL register done_spi and done_task (reset value 0) and act only on a rising edge, i.e. current=1 and previous=0; a level that is already high SHALL NOT count as done.
REQ-023 In IDLE, start with n_runs!=0 SHALL latch n_runs, t_gap, timeout, cfg_en and cfg_each, clear run_idx and err_timeout, and move to CFG if cfg_en=1, else to TASK.
REQ-024 In IDLE, start with n_runs=0 SHALL be ignored; start in any other state SHALL also be ignored.
REQ-025 CFG SHALL drive trigger_config=1 for exactly 1 cycle, clear the wait timer, and move to WAIT_CFG.
REQ-026 WAIT_CFG SHALL move to TASK on a done_spi rising edge.
REQ-027 TASK SHALL drive trigger_task=1 for exactly 1 cycle, clear the wait timer, and move to WAIT_TASK.
REQ-028 On a done_task rising edge in WAIT_TASK, run_idx SHALL increment.
REQ-029 After that increment, the next state SHALL be DONE if run_idx+1 equals the latched n_runs, else GAP.
REQ-030 GAP SHALL count the latched t_gap cycles, then enter CFG if cfg_en and cfg_each are both set, else TASK.
REQ-031 With t_gap=0, GAP SHALL last 1 cycle.
REQ-032 DONE SHALL pulse seq_done for 1 cycle, then return to IDLE.
REQ-033 In WAIT_CFG and WAIT_TASK the wait timer SHALL increment every cycle.
REQ-034 If the latched timeout is nonzero and the timer reaches it with no rising edge, the block SHALL enter ERR.
REQ-035 If the rising edge and the timeout fall in the same cycle, the rising edge SHALL win.
REQ-036 ERR SHALL set err_timeout, last 1 cycle, return to IDLE, and SHALL NOT pulse seq_done.
REQ-037 In any state other than IDLE, abort SHALL return the block to IDLE on the next edge and SHALL suppress any trigger or seq_done pulse in that cycle.
REQ-038 After an abort, run_idx SHALL hold its value and err_timeout SHALL be unchanged.
REQ-039 abort SHALL have priority over done edges, timeout and start.
REQ-040 run_idx SHALL NOT wrap, because the sequence ends when it equals n_runs.
REQ-041 Counter compares SHALL use the full CNT_W/RUN_W width, unsigned.
REQ-042 Input changes during a sequence SHALL have no effect until the next accepted start.

Reset
REQ-043 While rst_n=0, state SHALL be IDLE and every output, timer, latched register and edge register SHALL be 0, asynchronously.
REQ-044 After rst_n is released, the block SHALL accept start from the first clk edge.
REQ-045 Reset asserted in the middle of a sequence SHALL abandon it with no pulses emitted.

Verification
REQ-046 n_runs=3, t_gap=4, cfg_en=1, cfg_each=0, done pulses returned 5 cycles after each trigger -> 1 trigger_config, 3 trigger_task, run_idx 0→3, 1 seq_done, err_timeout=0.
REQ-047 cfg_each=1, n_runs=2 -> trigger order config, task, config, task; there SHALL be ≥4 GAP-state cycles between the first done_task and the second trigger_config.
REQ-048 timeout=10, done_spi never rises -> ERR at wait cycle 10, err_timeout=1, no trigger_task, busy=0 on the following cycle.
REQ-049 abort in WAIT_TASK on the same cycle as a done_task rising edge -> IDLE, run_idx unchanged, no seq_done.
REQ-050 Start with n_runs=0 -> busy stays 0; start while busy -> no effect; done_task held high before start -> no run counted until it falls and rises again.
REQ-051 rst_n pulled low during GAP -> every output 0 immediately; a later start behaves as REQ-046.
